// File: rtl/ram_stream_reader.sv
// ram_stream_reader: burst read sequencer for a dual-port RAM read port.
// Issues COUNT consecutive reads from BASE and streams the words out in
// address order on a valid/ready interface, absorbing the RAM's one-cycle
// read latency and consumer back-pressure through a two-entry skid buffer.

module ram_stream_reader #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [31:0]      i_base,
   input  logic [31:0]      i_count,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   input  logic [31:0]      i_ram_length,
   output logic             o_ram_we,
   output logic             o_ram_oe,
   output logic [31:0]      o_ram_address,
   input  logic [WIDTH-1:0] i_ram_dout,
   output logic             o_m_valid,
   input  logic             i_m_ready,
   output logic [WIDTH-1:0] o_m_data
);

   localparam int unsigned AW = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t           r_state;
   logic [AW-1:0]    r_addr_ptr;
   logic [AW-1:0]    r_issue_left;
   logic [AW-1:0]    r_accept_left;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   // Read issued last cycle; its data is on i_ram_dout this cycle.
   logic             r_inflight;
   // Output register (oldest word) and skid entry (next word).
   logic             r_m_valid;
   logic [WIDTH-1:0] r_m_data;
   logic             r_skid_valid;
   logic [WIDTH-1:0] r_skid_data;

   logic [1:0]       w_occ;
   logic             w_accept;
   logic             w_issue;
   logic [AW:0]      w_end;
   logic             w_oob;

   // Buffer occupancy counts held words plus the read still in flight.
   assign w_occ    = 2'(r_m_valid) + 2'(r_skid_valid) + 2'(r_inflight);
   assign w_accept = r_m_valid & i_m_ready;
   // A slot freed by this cycle's accept may be reused by this cycle's issue.
   assign w_issue  = (r_state == S_RUN) &&
                     ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_accept));

   // 33-bit bounds check so base+count cannot wrap.
   assign w_end    = {1'b0, i_base} + {1'b0, i_count};
   assign w_oob    = w_end > {1'b0, i_ram_length};

   assign o_ram_we      = 1'b0;
   assign o_ram_oe      = w_issue;
   assign o_ram_address = r_addr_ptr;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_err         = r_err;
   assign o_m_valid     = r_m_valid;
   assign o_m_data      = r_m_data;

   // Burst control: accept/reject start, count issues and accepts, end burst.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_addr_ptr    <= '0;
         r_issue_left  <= '0;
         r_accept_left <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (i_count == 32'd0) begin
                     r_done <= 1'b1;
                  end else if (w_oob) begin
                     r_done <= 1'b1;
                     r_err  <= 1'b1;
                  end else begin
                     r_addr_ptr    <= i_base;
                     r_issue_left  <= i_count;
                     r_accept_left <= i_count;
                     r_busy        <= 1'b1;
                     r_state       <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (w_issue) begin
                  r_addr_ptr   <= r_addr_ptr + 32'd1;
                  r_issue_left <= r_issue_left - 32'd1;
                  if (r_issue_left == 32'd1) begin
                     r_state <= S_FLUSH;
                  end
               end
               if (w_accept) begin
                  r_accept_left <= r_accept_left - 32'd1;
               end
            end
            S_FLUSH: begin
               if (w_accept) begin
                  r_accept_left <= r_accept_left - 32'd1;
                  if (r_accept_left == 32'd1) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Skid buffer: capture returning read data and keep words in order.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_inflight   <= 1'b0;
         r_m_valid    <= 1'b0;
         r_m_data     <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
      end else begin
         r_inflight <= w_issue;
         if (r_m_valid && !w_accept) begin
            // Output stalled: occupancy limit guarantees the skid is free here.
            if (r_inflight) begin
               r_skid_valid <= 1'b1;
               r_skid_data  <= i_ram_dout;
            end
         end else if (r_skid_valid) begin
            r_m_valid    <= 1'b1;
            r_m_data     <= r_skid_data;
            r_skid_valid <= r_inflight;
            if (r_inflight) begin
               r_skid_data <= i_ram_dout;
            end
         end else if (r_inflight) begin
            r_m_valid <= 1'b1;
            r_m_data  <= i_ram_dout;
         end else begin
            r_m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader: RAM model, per-cycle reference model of
// the burst stream, and directed scenarios with hand-computed expectations.

module tb_ram_stream_reader;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 1024;

   logic             clk;
   logic             i_reset;
   logic             i_start;
   logic [31:0]      i_base;
   logic [31:0]      i_count;
   logic             o_busy;
   logic             o_done;
   logic             o_err;
   logic [31:0]      i_ram_length;
   logic             o_ram_we;
   logic             o_ram_oe;
   logic [31:0]      o_ram_address;
   logic [WIDTH-1:0] i_ram_dout;
   logic             o_m_valid;
   logic             i_m_ready;
   logic [WIDTH-1:0] o_m_data;

   ram_stream_reader #(.WIDTH(WIDTH)) dut (
      .i_clk         (clk),
      .i_reset       (i_reset),
      .i_start       (i_start),
      .i_base        (i_base),
      .i_count       (i_count),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_err         (o_err),
      .i_ram_length  (i_ram_length),
      .o_ram_we      (o_ram_we),
      .o_ram_oe      (o_ram_oe),
      .o_ram_address (o_ram_address),
      .i_ram_dout    (i_ram_dout),
      .o_m_valid     (o_m_valid),
      .i_m_ready     (i_m_ready),
      .o_m_data      (o_m_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // RAM model: registered read, garbage on cycles without a read.
   logic [31:0] mem [DEPTH];
   always @(posedge clk) begin
      if (o_ram_oe && o_ram_address < DEPTH)
         i_ram_dout <= mem[o_ram_address[9:0]];
      else
         i_ram_dout <= $urandom;
   end

   // Consumer ready: 0 = always ready, 1 = random, 2 = stalled.
   int rmode = 0;
   always @(posedge clk) begin
      #1;
      case (rmode)
         0:       i_m_ready = 1'b1;
         1:       i_m_ready = 1'($urandom_range(0, 1));
         default: i_m_ready = 1'b0;
      endcase
   end

   // Reference model state.
   logic [31:0] exp_q[$];
   logic [31:0] addr_q[$];
   bit          m_busy;
   bit          exp_done, exp_err;
   bit          hold_prev;
   logic [31:0] hold_data;
   int          issued, accepted;
   int          cyc;
   int          t_start, first_valid_cyc, last_beat_cyc;
   int          n_done, n_err, n_beats, n_oe;
   logic [31:0] last_data;

   initial begin
      n_done = 0; n_err = 0; n_beats = 0; n_oe = 0; cyc = 0;
      t_start = 0; first_valid_cyc = -1; last_beat_cyc = 0; last_data = '0;
   end

   // Compare process: every cycle, outputs against the model.
   always @(negedge clk) begin
      if (i_reset) begin
         exp_q.delete();
         addr_q.delete();
         m_busy    = 1'b0;
         exp_done  = 1'b0;
         exp_err   = 1'b0;
         hold_prev = 1'b0;
         issued    = 0;
         accepted  = 0;
         first_valid_cyc = -1;
      end else begin
         cyc++;
         chk("done", o_done, exp_done);
         chk("err", o_err, exp_err);
         chk("busy", o_busy, m_busy);
         chk("we", o_ram_we, 0);
         if (o_done) n_done++;
         if (o_err) n_err++;
         exp_done = 1'b0;
         exp_err  = 1'b0;

         if (o_ram_oe) begin
            n_oe++;
            issued++;
            if (addr_q.size() == 0) chk("extra_issue", 1, 0);
            else chk("issue_addr", o_ram_address, addr_q.pop_front());
         end

         if (hold_prev) begin
            chk("hold_valid", o_m_valid, 1);
            chk("hold_data", o_m_data, hold_data);
         end

         // Start is evaluated with the pre-update busy view of this cycle.
         if (i_start && !m_busy) begin
            if (i_count == 0) begin
               exp_done = 1'b1;
            end else if ({1'b0, i_base} + {1'b0, i_count} > {1'b0, i_ram_length}) begin
               exp_done = 1'b1;
               exp_err  = 1'b1;
            end else begin
               m_busy = 1'b1;
               t_start = cyc;
               first_valid_cyc = -1;
               for (int i = 0; i < int'(i_count); i++) begin
                  exp_q.push_back(mem[10'(i_base + 32'(i))]);
                  addr_q.push_back(i_base + 32'(i));
               end
            end
         end

         if (o_m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

         if (o_m_valid && i_m_ready) begin
            accepted++;
            n_beats++;
            last_data = o_m_data;
            last_beat_cyc = cyc;
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else begin
               chk("beat_data", o_m_data, exp_q.pop_front());
               if (exp_q.size() == 0 && m_busy) begin
                  m_busy   = 1'b0;
                  exp_done = 1'b1;
               end
            end
         end

         chk("outstanding_le2", (issued - accepted) <= 2, 1);
         hold_prev = o_m_valid && !i_m_ready;
         hold_data = o_m_data;
      end
   end

   task automatic do_start(input logic [31:0] b, input logic [31:0] c);
      @(posedge clk); #1;
      i_start = 1'b1; i_base = b; i_count = c;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max);
      int prev;
      prev = n_done;
      for (int i = 0; i < max && n_done == prev; i++) @(posedge clk);
      if (n_done == prev) chk({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      int b, d, e, o;
      i_reset = 1'b1; i_start = 1'b0; i_base = '0; i_count = '0;
      i_ram_length = 32'd1024; i_m_ready = 1'b1; i_ram_dout = '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'(i + 100);
      repeat (3) @(posedge clk);
      #1 i_reset = 1'b0;
      @(negedge clk); #1;
      chk("rst_busy", o_busy, 0);
      chk("rst_valid", o_m_valid, 0);
      chk("rst_oe", o_ram_oe, 0);
      chk("rst_addr", o_ram_address, 0);
      chk("rst_data", o_m_data, 0);

      // Test 1: straight burst, always ready.
      rmode = 0; b = n_beats; e = n_err;
      do_start(32'd4, 32'd8);
      wait_done("t1", 100);
      chk("t1_beats", n_beats - b, 8);
      chk("t1_last", last_data, 111);
      chk("t1_first_lat", first_valid_cyc - t_start, 3);
      chk("t1_last_lat", last_beat_cyc - t_start, 10);
      chk("t1_err", n_err - e, 0);

      // Test 2: random back-pressure.
      rmode = 1; b = n_beats;
      do_start(32'd4, 32'd8);
      wait_done("t2", 400);
      chk("t2_beats", n_beats - b, 8);
      chk("t2_last", last_data, 111);

      // Test 3: consumer stalled for 20 cycles.
      rmode = 2; b = n_beats; o = n_oe;
      do_start(32'd4, 32'd8);
      repeat (20) @(posedge clk);
      chk("t3_oe_pulses", n_oe - o, 2);
      @(negedge clk); #1;
      chk("t3_valid", o_m_valid, 1);
      chk("t3_data", o_m_data, 104);
      rmode = 0;
      wait_done("t3", 100);
      chk("t3_beats", n_beats - b, 8);
      chk("t3_last", last_data, 111);

      // Test 4: bounds at end of RAM.
      b = n_beats;
      do_start(32'd1020, 32'd4);
      wait_done("t4a", 100);
      chk("t4a_beats", n_beats - b, 4);
      chk("t4a_last", last_data, 1123);
      o = n_oe; e = n_err; d = n_done;
      do_start(32'd1020, 32'd5);
      wait_done("t4b", 20);
      chk("t4b_err", n_err - e, 1);
      chk("t4b_oe", n_oe - o, 0);
      e = n_err;
      do_start(32'd1020, 32'd0);
      wait_done("t4c", 20);
      chk("t4c_err", n_err - e, 0);
      chk("t4c_oe", n_oe - o, 0);
      chk("t4_dones", n_done - d, 2);

      // Test 6: start while busy is ignored.
      b = n_beats; d = n_done;
      do_start(32'd4, 32'd8);
      repeat (2) @(posedge clk);
      do_start(32'd0, 32'd3);
      wait_done("t6", 100);
      repeat (10) @(posedge clk);
      chk("t6_beats", n_beats - b, 8);
      chk("t6_dones", n_done - d, 1);
      chk("t6_last", last_data, 111);

      // Test 5: reset mid-burst, then a fresh burst.
      b = n_beats;
      do_start(32'd4, 32'd8);
      for (int i = 0; i < 50 && (n_beats - b) < 3; i++) @(posedge clk);
      chk("t5_three_beats", n_beats - b >= 3, 1);
      #1 i_reset = 1'b1;
      #1;
      chk("t5_busy", o_busy, 0);
      chk("t5_done", o_done, 0);
      chk("t5_err", o_err, 0);
      chk("t5_valid", o_m_valid, 0);
      chk("t5_oe", o_ram_oe, 0);
      chk("t5_addr", o_ram_address, 0);
      chk("t5_data", o_m_data, 0);
      @(posedge clk); #1 i_reset = 1'b0;
      b = n_beats; d = n_done;
      do_start(32'd0, 32'd2);
      wait_done("t5", 50);
      repeat (5) @(posedge clk);
      chk("t5_beats", n_beats - b, 2);
      chk("t5_last", last_data, 101);
      chk("t5_dones", n_done - d, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
